// File: rtl/ssd_scan_ctrl.sv
// Scan controller for an N-digit seven-segment display.
// Double-buffered frame, leading-zero blanking, anti-ghosting guard cycles.
module ssd_scan_ctrl #(
  parameter int N_DIGITS  = 4,
  parameter int SLOT_CYC  = 50000,
  parameter int GUARD_CYC = 2,
  parameter int AN_ACT_LO = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  blank_lz,
  output logic [3:0]            bcd_out,
  output logic [N_DIGITS-1:0]   anode,
  output logic                  dp_n,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int CNT_W = $clog2(SLOT_CYC);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(SLOT_CYC - 1);
  localparam logic [CNT_W-1:0]    CNT_GUARD = CNT_W'(GUARD_CYC);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF    = (AN_ACT_LO != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic [IDX_W-1:0] idx_r, idx_nx_s;
  logic             slot_end_s, frame_end_s;

  logic [N_DIGITS-1:0][3:0] act_code_r, pnd_code_r;
  logic [N_DIGITS-1:0]      act_dp_r, pnd_dp_r;
  logic                     act_blz_r, pnd_blz_r, pending_r;

  logic [N_DIGITS-1:0] mask_s, an_hot_s, an_drv_s;
  logic [3:0]          eff_code_s;
  logic                eff_dp_s, an_on_s;

  logic [3:0]          bcd_r;
  logic [N_DIGITS-1:0] anode_r;
  logic                dp_n_r, frame_done_r;

  // A digit is blanked while it and every more significant digit are zero; digit 0 always shows.
  function automatic logic [N_DIGITS-1:0] blank_mask(input logic [N_DIGITS-1:0][3:0] codes,
                                                     input logic blz);
    logic                lz;
    logic [N_DIGITS-1:0] mask;
    lz   = blz;
    mask = '0;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      if (lz && (codes[k] == 4'h0)) begin
        mask[k] = 1'b1;
      end else begin
        lz = 1'b0;
      end
    end
    return mask;
  endfunction

  // Next slot counter / digit index.
  always_comb begin
    cnt_nx_s    = cnt_r;
    idx_nx_s    = idx_r;
    slot_end_s  = (cnt_r == CNT_LAST);
    frame_end_s = slot_end_s && (idx_r == IDX_LAST);
    if (slot_end_s) begin
      cnt_nx_s = '0;
      if (idx_r == IDX_LAST) begin
        idx_nx_s = '0;
      end else begin
        idx_nx_s = idx_r + IDX_W'(1);
      end
    end else begin
      cnt_nx_s = cnt_r + CNT_W'(1);
      idx_nx_s = idx_r;
    end
  end

  // Slot counter and digit index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      idx_r <= '0;
    end else begin
      cnt_r <= cnt_nx_s;
      idx_r <= idx_nx_s;
    end
  end

  // Active buffer only changes at the frame boundary, so a frame never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_code_r <= {N_DIGITS{4'hF}};
      act_dp_r   <= '0;
      act_blz_r  <= 1'b0;
      pnd_code_r <= {N_DIGITS{4'hF}};
      pnd_dp_r   <= '0;
      pnd_blz_r  <= 1'b0;
      pending_r  <= 1'b0;
    end else if (frame_end_s) begin
      if (load) begin
        act_code_r <= digits_in;
        act_dp_r   <= dp_in;
        act_blz_r  <= blank_lz;
      end else if (pending_r) begin
        act_code_r <= pnd_code_r;
        act_dp_r   <= pnd_dp_r;
        act_blz_r  <= pnd_blz_r;
      end
      pending_r <= 1'b0;
    end else if (load) begin
      pnd_code_r <= digits_in;
      pnd_dp_r   <= dp_in;
      pnd_blz_r  <= blank_lz;
      pending_r  <= 1'b1;
    end
  end

  // Effective code, decimal point and anode pattern for the current slot.
  always_comb begin
    mask_s     = blank_mask(act_code_r, act_blz_r);
    eff_code_s = mask_s[idx_r] ? 4'hF : act_code_r[idx_r];
    eff_dp_s   = act_dp_r[idx_r] & ~mask_s[idx_r];
    an_on_s    = (cnt_r >= CNT_GUARD);
    an_hot_s   = '0;
    if (an_on_s) begin
      an_hot_s[idx_r] = 1'b1;
    end else begin
      an_hot_s = '0;
    end
    an_drv_s = (AN_ACT_LO != 0) ? ~an_hot_s : an_hot_s;
  end

  // Output registers; frame_done is computed from the next state so it lines up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_r        <= 4'hF;
      anode_r      <= AN_OFF;
      dp_n_r       <= 1'b1;
      frame_done_r <= 1'b0;
    end else begin
      bcd_r        <= eff_code_s;
      anode_r      <= an_drv_s;
      dp_n_r       <= an_on_s ? ~eff_dp_s : 1'b1;
      frame_done_r <= (cnt_nx_s == CNT_LAST) && (idx_nx_s == IDX_LAST);
    end
  end

  assign bcd_out    = bcd_r;
  assign anode      = anode_r;
  assign dp_n       = dp_n_r;
  assign frame_done = frame_done_r;
  assign pending    = pending_r;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Randomized scoreboard bench for ssd_scan_ctrl (4 digits, 8-cycle slots, 2 guard cycles).
module tb_ssd_scan_ctrl;
  localparam int N  = 4;
  localparam int S  = 8;
  localparam int G  = 2;
  localparam int FR = N * S;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  bcd_out;
  logic [3:0]  anode;
  logic        dp_n, frame_done, pending;

  ssd_scan_ctrl #(.N_DIGITS(N), .SLOT_CYC(S), .GUARD_CYC(G), .AN_ACT_LO(1)) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .bcd_out(bcd_out), .anode(anode), .dp_n(dp_n),
    .frame_done(frame_done), .pending(pending)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [4:0] exp_q[$];
  logic [4:0] cur_exp = 5'h1F;
  int last_ld = -1;
  int prev_ld = -1;
  logic [15:0] m_dig = 16'hFFFF;
  logic [3:0]  m_dp = 4'h0;
  logic        m_blz = 1'b0;

  // cycle number since reset release: during cycle t the scan state is slot t/8, count t%8
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // expected display of the frame about to start: the latest load before it
  task automatic push_frame();
    for (int d = 0; d < N; d++) begin
      logic [3:0] c;
      logic       dpb;
      c   = 4'((m_dig >> (4 * d)) & 16'hF);
      dpb = m_dp[d];
      if (m_blz && d > 0 && (m_dig >> (4 * d)) == 16'h0) begin
        c   = 4'hF;
        dpb = 1'b0;
      end
      exp_q.push_back({~dpb, c});
    end
  endtask

  task automatic step(input bit ld, input logic [15:0] dg, input logic [3:0] dp, input bit bz);
    load      = ld;
    digits_in = dg;
    dp_in     = dp;
    blank_lz  = bz;
    if (ld) begin
      prev_ld = last_ld;
      last_ld = cyc;
      m_dig   = dg;
      m_dp    = dp;
      m_blz   = bz;
    end
    @(posedge clk);
    #1;
    load = 1'b0;
    if (cyc % FR == 0) push_frame();
  endtask

  task automatic wait_to(input int k);
    for (int i = 0; i < FR && (cyc % FR) != k; i++) step(1'b0, 16'h0, 4'h0, 1'b0);
  endtask

  task automatic next_frame();
    step(1'b0, 16'h0, 4'h0, 1'b0);
    wait_to(0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_ld = -1;
    prev_ld = -1;
    m_dig   = 16'hFFFF;
    m_dp    = 4'h0;
    m_blz   = 1'b0;
  endtask

  // monitor: anode/frame_done/pending every cycle, pops one digit expectation per anode window
  always @(negedge clk) begin
    if (mon_en) begin
      int t, d, ll;
      bit act, pexp;
      logic [3:0] ea;
      t   = cyc;
      act = (t >= 1) && (((t - 1) % S) >= G);
      d   = ((t - 1) / S) % N;
      ea  = act ? ~(4'b0001 << d) : 4'hF;
      chk("anode", 32'(anode), 32'(ea));
      chk("frame_done", 32'(frame_done), 32'((t % FR) == FR - 1));
      ll   = (last_ld == t) ? prev_ld : last_ld;
      pexp = (ll >= 0) && (ll >= (t / FR) * FR);
      chk("pending", 32'(pending), 32'(pexp));
      if (t == 0) begin
        chk("bcd_reset", 32'(bcd_out), 32'h0000000F);
        chk("dp_n_reset", 32'(dp_n), 32'h1);
      end else if (act) begin
        if (((t - 1) % S) == G) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL queue_underflow cyc=%0d got=empty expected=entry", t);
            cur_exp = 5'h1F;
          end else begin
            cur_exp = exp_q.pop_front();
          end
        end
        chk("bcd_out", 32'(bcd_out), 32'(cur_exp[3:0]));
        chk("dp_n", 32'(dp_n), 32'(cur_exp[4]));
      end else begin
        chk("dp_n_guard", 32'(dp_n), 32'h1);
      end
    end
  end

  initial begin
    logic [15:0] rv;
    int nsig;
    bit ld;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    push_frame();

    repeat (2 * FR) step(1'b0, 16'h0, 4'h0, 1'b0);

    wait_to(10); step(1'b1, 16'h1234, 4'h0, 1'b0); next_frame(); next_frame();
    wait_to(3);  step(1'b1, 16'h0050, 4'h0, 1'b1); next_frame(); next_frame();
    wait_to(3);  step(1'b1, 16'h0000, 4'h0, 1'b1); next_frame(); next_frame();
    wait_to(4);  step(1'b1, 16'h0A0B, 4'h0, 1'b1); next_frame(); next_frame();
    wait_to(5);  step(1'b1, 16'h1111, 4'h0, 1'b0);
    wait_to(20); step(1'b1, 16'h2222, 4'h0, 1'b0); next_frame(); next_frame();
    wait_to(31); step(1'b1, 16'h3333, 4'h0, 1'b0); next_frame(); next_frame();
    wait_to(8);  step(1'b1, 16'h9876, 4'b0100, 1'b0); next_frame(); next_frame();

    repeat (20 * FR) begin
      nsig = int'($urandom_range(0, 4));
      rv   = 16'($urandom) & 16'((32'h1 << (4 * nsig)) - 1);
      ld   = ((cyc % FR) == FR - 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      step(ld, rv, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    // asynchronous reset at digit 2, count 5, with a frame pending
    wait_to(15); step(1'b1, 16'h4567, 4'b1010, 1'b0);
    wait_to(21);
    chk("pending_before_rst", 32'(pending), 32'h1);
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk("rst_bcd", 32'(bcd_out), 32'h0000000F);
    chk("rst_anode", 32'(anode), 32'h0000000F);
    chk("rst_dp_n", 32'(dp_n), 32'h1);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    push_frame();
    next_frame(); next_frame();
    wait_to(12); step(1'b1, 16'h0809, 4'b0001, 1'b1); next_frame(); next_frame();

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
